serial_adder_sub: RTL and testbench



---
 rtl/serial_adder_sub_if.sv | 25 ++
 rtl/serial_adder_sub.sv | 98 +++++++++
 tb/tb_serial_adder_sub.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_sub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The requester drives start and the operands; the arithmetic unit returns status and result.
interface serial_adder_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout
    );
endinterface

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first,
// one bit per clock, with a start/busy/done handshake and held result registers.
module serial_adder_sub #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_sub_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] rs_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sum_bit    = ra[0] ^ rb[0] ^ carry;
        carry_next = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
        rs_next    = rs >> 1;
        rs_next[WIDTH-1] = sum_bit;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand/result shift registers are few flops, so all of them reset along with the FSM.
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            rs     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1; the user carry-in does not apply.
                        ra     <= bus.a;
                        rb     <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub ? 1'b1 : bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    carry <= carry_next;
                    rs    <= rs_next;
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        s_q    <= rs_next;
                        cout_q <= carry_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_sub.sv
// Self-checking bench for serial_adder_sub: directed WIDTH=4 cases, back-to-back start,
// asynchronous reset abort, and 200 random WIDTH=8 operations against a scoreboard.
module tb_serial_adder_sub;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_sub_if #(.WIDTH(4)) b4 ();
    serial_adder_sub_if #(.WIDTH(8)) b8 ();

    serial_adder_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    serial_adder_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] q4[$];
    logic [32:0] q8[$];
    logic [32:0] held4 = '0;
    logic [32:0] held8 = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {cout, s} with cout at bit w, computed from the arithmetic definition.
    function automatic logic [32:0] model(input int w, input bit sb, input logic [31:0] a,
                                          input logic [31:0] b, input bit ci);
        logic [32:0] r;
        logic [32:0] mask;
        mask = (33'd1 << w) - 33'd1;
        if (sb) begin
            r = ({1'b0, a} - {1'b0, b}) & mask;
            if (a >= b) r = r | (33'd1 << w);
        end else begin
            r = {1'b0, a} + {1'b0, b} + 33'(ci);
        end
        return r;
    endfunction

    // Scoreboards: results are popped on done and must otherwise hold steady.
    always @(negedge clk) begin
        if (!rst_n) begin
            held4 = '0;
            check("rst4_out", {b4.busy, b4.done, b4.cout, b4.s}, '0);
        end else if (b4.done === 1'b1) begin
            if (q4.size() == 0) check("done4_unexpected", b4.done, 1'b0);
            else begin
                held4 = q4.pop_front();
                check("res4", {b4.cout, b4.s}, held4);
            end
        end else begin
            check("hold4", {b4.cout, b4.s}, held4);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held8 = '0;
            check("rst8_out", {b8.busy, b8.done, b8.cout, b8.s}, '0);
        end else if (b8.done === 1'b1) begin
            if (q8.size() == 0) check("done8_unexpected", b8.done, 1'b0);
            else begin
                held8 = q8.pop_front();
                check("res8", {b8.cout, b8.s}, held8);
            end
        end
    end

    task automatic op4(input bit sb, input logic [3:0] a, input logic [3:0] b, input bit ci,
                       input logic [4:0] lit);
        int n;
        @(posedge clk); #1;
        b4.start = 1'b1; b4.sub = sb; b4.a = a; b4.b = b; b4.cin = ci;
        q4.push_back(model(4, sb, a, b, ci));
        @(posedge clk); #1;
        b4.start = 1'b0; b4.sub = ~sb; b4.a = ~a; b4.b = ~b; b4.cin = ~ci;
        check("busy4_rise", b4.busy, 1'b1);
        n = 0;
        @(negedge clk);
        while (b4.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy4_len", n, 4);
        check("done4_pulse", b4.done, 1'b1);
        check("lit4", {b4.cout, b4.s}, lit);
        @(negedge clk);
        check("done4_fall", b4.done, 1'b0);
    endtask

    task automatic op8(input bit sb, input logic [7:0] a, input logic [7:0] b, input bit ci);
        int n;
        @(posedge clk); #1;
        b8.start = 1'b1; b8.sub = sb; b8.a = a; b8.b = b; b8.cin = ci;
        q8.push_back(model(8, sb, a, b, ci));
        @(posedge clk); #1;
        b8.start = 1'b0; b8.a = $urandom; b8.b = $urandom; b8.cin = ~ci;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b8.done !== 1'b1 && n < 40);
        check("lat8", n, 9);
        @(negedge clk);
    endtask

    initial begin
        b4.start = 1'b0; b4.sub = 1'b0; b4.a = '0; b4.b = '0; b4.cin = 1'b0;
        b8.start = 1'b0; b8.sub = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
        #12;
        check("reset4", {b4.busy, b4.done, b4.cout, b4.s}, '0);
        check("reset8", {b8.busy, b8.done, b8.cout, b8.s}, '0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        op4(1'b0, 4'b0011, 4'b0101, 1'b0, 5'b0_1000);
        op4(1'b0, 4'b1111, 4'b0001, 1'b0, 5'b1_0000);
        op4(1'b0, 4'b0111, 4'b0111, 1'b1, 5'b0_1111);
        op4(1'b1, 4'b0101, 4'b0011, 1'b1, 5'b1_0010);
        op4(1'b1, 4'b0011, 4'b0101, 1'b0, 5'b0_1110);
        op4(1'b1, 4'b1010, 4'b1010, 1'b0, 5'b1_0000);

        // start held high with operands changing every cycle: one accept per 6 cycles.
        b4.start = 1'b1;
        b4.sub = 1'($urandom); b4.a = 4'($urandom); b4.b = 4'($urandom); b4.cin = 1'($urandom);
        for (int j = 0; j < 5 * 6; j++) begin
            if (j % 6 == 0) q4.push_back(model(4, b4.sub, b4.a, b4.b, b4.cin));
            @(posedge clk); #1;
            b4.sub = 1'($urandom); b4.a = 4'($urandom); b4.b = 4'($urandom); b4.cin = 1'($urandom);
        end
        b4.start = 1'b0;
        repeat (8) @(negedge clk);
        check("hold_drain4", q4.size(), 0);

        // Asynchronous reset two cycles into an operation aborts it.
        op4(1'b0, 4'b0011, 4'b0101, 1'b0, 5'b0_1000);
        @(posedge clk); #1;
        b4.start = 1'b1; b4.sub = 1'b0; b4.a = 4'b0110; b4.b = 4'b0011; b4.cin = 1'b0;
        @(posedge clk); #1;
        b4.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", b4.busy, 1'b0);
        check("abort_done", b4.done, 1'b0);
        check("abort_s", {b4.cout, b4.s}, 5'b0_0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        op4(1'b0, 4'b0001, 4'b0001, 1'b0, 5'b0_0010);

        for (int i = 0; i < 200; i++) begin
            op8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            if (i % 50 == 49) $display("[TB] random op %0d: s=%0h cout=%0b", i + 1, b8.s, b8.cout);
        end

        repeat (4) @(negedge clk);
        check("drain4", q4.size(), 0);
        check("drain8", q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
